// File: rtl/fir_coeff_loader.sv
// Shadow coefficient bank written byte-wise from the register side; on commit it waits for a
// sample boundary and streams every tap into the FIR coefficient file, one tap per cycle.
module fir_coeff_loader #(
  parameter int NUM_TAPS = 10,
  parameter int COEF_W   = 24,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data,
  input  logic              sample_tick,
  input  logic              fir_busy,
  output logic              coef_we,
  output logic [IDX_W-1:0]  coef_idx,
  output logic [COEF_W-1:0] coef_data,
  output logic              bypass,
  output logic [7:0]        cfg,
  output logic              busy,
  output logic              commit_done,
  output logic              wr_err
);

  localparam int              NUM_BYTES = 3 * NUM_TAPS;
  localparam logic [7:0]      LAST_ADDR = 8'(NUM_BYTES);
  localparam logic [IDX_W:0]  TAP_END   = (IDX_W+1)'(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, ARMED, LOAD, DONE} state_e;

  state_e              state_q, state_d;
  logic [7:0]          shadow_q [NUM_BYTES];
  logic [7:0]          shadow_d [NUM_BYTES];
  logic [7:1]          cfg_q, cfg_d;
  logic [IDX_W:0]      idx_q, idx_d;
  logic                pending_q, pending_d;
  logic                coef_we_q, coef_we_d;
  logic [IDX_W-1:0]    coef_idx_q, coef_idx_d;
  logic [COEF_W-1:0]   coef_data_q, coef_data_d;
  logic                busy_q, busy_d;
  logic                commit_done_q, commit_done_d;
  logic                wr_err_q, wr_err_d;

  logic                cfg_wr, commit_wr, byte_wr, loading, issue;
  logic [IDX_W:0]      issue_idx;
  logic [COEF_W-1:0]   tap_sel;

  always_comb begin
    cfg_wr    = wr_en && (wr_addr == 8'd0);
    commit_wr = cfg_wr && wr_data[0];
    // The shadow is frozen from the first tap write until the commit has been reported.
    loading   = (state_q == LOAD) || (state_q == DONE);
    byte_wr   = wr_en && (wr_addr != 8'd0) && (wr_addr <= LAST_ADDR) && !loading;
    wr_err_d  = wr_en && ((wr_addr > LAST_ADDR) || ((wr_addr != 8'd0) && loading));

    shadow_d = shadow_q;
    for (int i = 0; i < NUM_BYTES; i++)
      if (byte_wr && (wr_addr == 8'(i + 1))) shadow_d[i] = wr_data;
    cfg_d = cfg_wr ? wr_data[7:1] : cfg_q;

    issue_idx = (state_q == LOAD) ? idx_q : '0;
    tap_sel   = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      if (issue_idx == (IDX_W+1)'(k))
        tap_sel = COEF_W'({shadow_q[3*k+2], shadow_q[3*k+1], shadow_q[3*k]});

    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    coef_we_d   = 1'b0;
    coef_idx_d  = coef_idx_q;
    coef_data_d = coef_data_q;
    issue       = 1'b0;

    // Writes are issued one edge ahead so coef_we is already high in the first LOAD cycle.
    case (state_q)
      IDLE:  if (commit_wr) state_d = ARMED;
      ARMED: if (sample_tick) begin
        state_d = LOAD;
        idx_d   = '0;
        issue   = !fir_busy;
      end
      LOAD: begin
        if (commit_wr) pending_d = 1'b1;
        if (idx_q == TAP_END) state_d = DONE;
        else                  issue   = !fir_busy;
      end
      DONE: begin
        state_d   = (pending_q || commit_wr) ? ARMED : IDLE;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      coef_we_d   = 1'b1;
      coef_idx_d  = issue_idx[IDX_W-1:0];
      coef_data_d = tap_sel;
      idx_d       = issue_idx + 1'b1;
    end

    busy_d        = (state_d != IDLE);
    commit_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      for (int i = 0; i < NUM_BYTES; i++) shadow_q[i] <= '0;
      cfg_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      coef_we_q     <= 1'b0;
      coef_idx_q    <= '0;
      coef_data_q   <= '0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      cfg_q         <= cfg_d;
      idx_q         <= idx_d;
      pending_q     <= pending_d;
      coef_we_q     <= coef_we_d;
      coef_idx_q    <= coef_idx_d;
      coef_data_q   <= coef_data_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      wr_err_q      <= wr_err_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr == 8'd0) rd_data = {cfg_q, busy_q};
    for (int i = 0; i < NUM_BYTES; i++)
      if (rd_addr == 8'(i + 1)) rd_data = shadow_q[i];
  end

  assign coef_we     = coef_we_q;
  assign coef_idx    = coef_idx_q;
  assign coef_data   = coef_data_q;
  assign bypass      = cfg_q[1];
  assign cfg         = {cfg_q, 1'b0};
  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: register access, commit timing, stalls, rejects, reset.
module tb_fir_coeff_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_addr, wr_data, rd_addr, rd_data;
  logic        sample_tick, fir_busy;
  logic        coef_we;
  logic [3:0]  coef_idx;
  logic [23:0] coef_data;
  logic        bypass;
  logic [7:0]  cfg;
  logic        busy, commit_done, wr_err;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_tap [10];

  fir_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .sample_tick(sample_tick), .fir_busy(fir_busy),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data), .bypass(bypass),
    .cfg(cfg), .busy(busy), .commit_done(commit_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
  endtask

  // Called in the first cycle after the tick edge; follows the load through commit_done.
  task automatic run_load(input string tag, input int exp_window, input int stall_at,
                          input int err_at, input int commit_at, input logic exp_busy_after);
    int nxt = 0, first = -1, last = -1, done_cyc = -1;
    for (int c = 0; c < 40 && done_cyc < 0; c++) begin
      if (coef_we) begin
        chk({tag, "_idx"}, coef_idx, nxt);
        chk({tag, "_data"}, coef_data, exp_tap[nxt % 10]);
        nxt++;
        if (first < 0) first = c;
        last = c;
      end
      if (err_at >= 0 && c == err_at + 1) chk({tag, "_wr_err"}, wr_err, 1'b1);
      if (commit_done) done_cyc = c;
      wr_en    = 1'b0;
      fir_busy = (stall_at >= 0 && c >= stall_at && c < stall_at + 3);
      if (c == err_at)    begin wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'hEE; end
      if (c == commit_at) begin wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'h01; end
      if (done_cyc < 0) step();
    end
    wr_en = 1'b0; fir_busy = 1'b0;
    chk({tag, "_ntaps"}, nxt, 10);
    chk({tag, "_window"}, last - first + 1, exp_window);
    chk({tag, "_done_cyc"}, done_cyc, last + 1);
    step();
    chk({tag, "_done_pulse"}, commit_done, 1'b0);
    chk({tag, "_busy_after"}, busy, exp_busy_after);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    sample_tick = 1'b0; fir_busy = 1'b0;
    for (int i = 0; i < 10; i++) exp_tap[i] = '0;
    #12;
    chk("rst_coef_we", coef_we, 1'b0);
    chk("rst_coef_idx", coef_idx, 4'd0);
    chk("rst_coef_data", coef_data, 24'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", commit_done, 1'b0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_cfg", cfg, 8'h00);
    chk("rst_bypass", bypass, 1'b0);
    rd_chk("rst_rd0", 8'd0, 8'h00);
    rst_n = 1'b1;
    step();

    // Basic commit of tap0 = 0x123456; a tick in the commit cycle is ignored
    wr(8'd1, 8'h56); wr(8'd2, 8'h34); wr(8'd3, 8'h12);
    rd_chk("rd_b1", 8'd1, 8'h56);
    rd_chk("rd_b3", 8'd3, 8'h12);
    exp_tap[0] = 24'h123456;
    sample_tick = 1'b1;
    wr(8'd0, 8'h01);
    sample_tick = 1'b0;
    chk("armed_busy", busy, 1'b1);
    chk("armed_cfg", cfg, 8'h00);
    chk("early_tick_ignored", coef_we, 1'b0);
    step();
    chk("armed_no_we", coef_we, 1'b0);
    tick();
    run_load("basic", 10, -1, -1, -1, 1'b0);

    // fir_busy stall plus a rejected shadow write during LOAD
    wr(8'd4, 8'h11); wr(8'd5, 8'h22); wr(8'd6, 8'h33);
    exp_tap[1] = 24'h332211;
    wr(8'd0, 8'h01);
    tick();
    run_load("stall", 13, 3, 6, -1, 1'b0);
    rd_chk("tap1_kept", 8'd5, 8'h22);

    // Out-of-range write
    wr(8'd31, 8'hAA);
    chk("oor_wr_err", wr_err, 1'b1);
    rd_chk("oor_rd31", 8'd31, 8'h00);
    rd_chk("oor_rd1", 8'd1, 8'h56);
    step();
    chk("oor_err_pulse", wr_err, 1'b0);

    // Commit during LOAD re-arms; second tick runs a full reload
    wr(8'd0, 8'h01);
    tick();
    run_load("pend1", 10, -1, -1, 4, 1'b1);
    tick();
    run_load("pend2", 10, -1, -1, -1, 1'b0);

    // cfg with bypass
    wr(8'd0, 8'h03);
    chk("cfg_bypass", bypass, 1'b1);
    chk("cfg_val", cfg, 8'h02);
    rd_chk("cfg_rd_armed", 8'd0, 8'h03);
    tick();
    run_load("cfgload", 10, -1, -1, -1, 1'b0);
    rd_chk("cfg_rd_idle", 8'd0, 8'h02);
    chk("cfg_bypass_kept", bypass, 1'b1);

    // Asynchronous reset mid-LOAD
    wr(8'd0, 8'h01);
    tick();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (coef_we && coef_idx == 4'd4) found = 1'b1;
      else step();
    end
    chk("reach_idx4", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_coef_we", coef_we, 1'b0);
    chk("arst_coef_idx", coef_idx, 4'd0);
    chk("arst_coef_data", coef_data, 24'd0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_cfg", cfg, 8'h00);
    rst_n = 1'b1;
    step();
    rd_chk("arst_rd1", 8'd1, 8'h00);
    rd_chk("arst_rd5", 8'd5, 8'h00);
    step();
    chk("arst_idle_we", coef_we, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
